// File: rtl/cover_pkg.sv
// Shared constants, types and helpers for the toggle cover collectors.
package cover_pkg;

   localparam int COVER_TOTAL   = 38253;
   localparam int COVER_IDX_W   = 64;
   localparam int MAX_WIDTH     = 1024;
   localparam int MAX_COUNT_W   = 11;

   typedef logic [COVER_IDX_W-1:0] cover_idx_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

   // Callers zero-extend their bitmap to MAX_WIDTH bits.
   function automatic logic [MAX_COUNT_W-1:0] popcount(input logic [MAX_WIDTH-1:0] bits);
      logic [MAX_COUNT_W-1:0] total;
      total = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         total = total + MAX_COUNT_W'(bits[i]);
      end
      return total;
   endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// Combinational lowest-set-bit finder used to pick the next pending cover point.
module cover_prio_enc #(
   parameter int WIDTH = 23,
   parameter int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] bits,
   output logic             any,
   output logic [POS_W-1:0] pos
);

   // Scanning downward lets the lowest set bit be the last one written.
   always_comb begin
      any = 1'b0;
      pos = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (bits[i]) begin
            any = 1'b1;
            pos = POS_W'(i);
         end
      end
   end

endmodule

// File: rtl/cover_toggle_collector.sv
// Sticky per-point toggle coverage: records first hits and streams each newly
// covered point once as a global cover index, with a running covered count.
module cover_toggle_collector #(
   parameter int WIDTH       = 23,
   parameter int COVER_INDEX = 0,
   parameter int COVER_TOTAL = cover_pkg::COVER_TOTAL,
   parameter int IDX_W       = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         clear,
   input  logic [WIDTH-1:0]             valid,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [IDX_W-1:0]             out_index,
   output logic [$clog2(WIDTH+1)-1:0]   hit_count,
   output logic                         all_hit
);

   import cover_pkg::*;

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   generate
      if (WIDTH < 1 || WIDTH > MAX_WIDTH || COVER_INDEX < 0 ||
          COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_params
         $error("cover_toggle_collector: illegal WIDTH/COVER_INDEX/COVER_TOTAL");
      end
   endgenerate

   logic [WIDTH-1:0] hit;
   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] new_hits;
   logic [WIDTH-1:0] pending_next;
   logic [WIDTH-1:0] hit_next;
   logic [CNT_W-1:0] count_next;
   logic             any_pending;
   logic [POS_W-1:0] next_pos;
   logic             load;
   logic             take;
   out_state_t       state;

   cover_prio_enc #(
      .WIDTH (WIDTH),
      .POS_W (POS_W)
   ) u_prio (
      .bits (pending),
      .any  (any_pending),
      .pos  (next_pos)
   );

   assign out_valid = (state == FULL);

   // The output register may reload whenever it is empty or its beat is accepted;
   // a clear cycle forgets pending points, so nothing is loaded from them.
   always_comb begin
      new_hits = valid & ~hit & {WIDTH{enable & ~clear}};
      load     = (state == EMPTY) | out_ready;
      take     = load & any_pending & ~clear;

      hit_next     = hit | new_hits;
      pending_next = pending | new_hits;
      if (take) begin
         pending_next[next_pos] = 1'b0;
      end
      count_next = hit_count + CNT_W'(popcount(MAX_WIDTH'(new_hits)));

      if (clear) begin
         hit_next     = '0;
         pending_next = '0;
         count_next   = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hit       <= '0;
         pending   <= '0;
         hit_count <= '0;
         all_hit   <= 1'b0;
         state     <= EMPTY;
         out_index <= '0;
      end else begin
         hit       <= hit_next;
         pending   <= pending_next;
         hit_count <= count_next;
         all_hit   <= (count_next == CNT_W'(WIDTH));
         if (load) begin
            state <= take ? FULL : EMPTY;
            if (take) begin
               out_index <= IDX_W'(COVER_INDEX) + IDX_W'(next_pos);
            end
         end
      end
   end

endmodule
